// File: rtl/bp_me_mem_serdes_if.sv
// Handshake bundle for bp_me_mem_serdes: wide mem_cmd/mem_resp on the cache side, narrow beats on the link side.
// Directions are named from the serdes' point of view; the serdes uses the slave modport.
interface bp_me_mem_serdes_if #(
    parameter int unsigned paddr_width_p     = 40,
    parameter int unsigned cce_block_width_p = 512,
    parameter int unsigned beat_width_p      = 64
);
    localparam int unsigned hdr_w_lp = paddr_width_p + 7;
    localparam int unsigned msg_w_lp = hdr_w_lp + cce_block_width_p;

    logic [msg_w_lp-1:0]     mem_cmd_i;
    logic                    mem_cmd_v_i;
    logic                    mem_cmd_ready_o;
    logic [hdr_w_lp-1:0]     link_cmd_header_o;
    logic [beat_width_p-1:0] link_cmd_data_o;
    logic                    link_cmd_last_o;
    logic                    link_cmd_v_o;
    logic                    link_cmd_yumi_i;
    logic [hdr_w_lp-1:0]     link_resp_header_i;
    logic [beat_width_p-1:0] link_resp_data_i;
    logic                    link_resp_last_i;
    logic                    link_resp_v_i;
    logic                    link_resp_ready_o;
    logic [msg_w_lp-1:0]     mem_resp_o;
    logic                    mem_resp_v_o;
    logic                    mem_resp_yumi_i;

    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, link_cmd_yumi_i,
        input  link_resp_header_i, link_resp_data_i, link_resp_last_i, link_resp_v_i, mem_resp_yumi_i,
        output mem_cmd_ready_o, link_cmd_header_o, link_cmd_data_o, link_cmd_last_o, link_cmd_v_o,
        output link_resp_ready_o, mem_resp_o, mem_resp_v_o
    );

    modport master (
        output mem_cmd_i, mem_cmd_v_i, link_cmd_yumi_i,
        output link_resp_header_i, link_resp_data_i, link_resp_last_i, link_resp_v_i, mem_resp_yumi_i,
        input  mem_cmd_ready_o, link_cmd_header_o, link_cmd_data_o, link_cmd_last_o, link_cmd_v_o,
        input  link_resp_ready_o, mem_resp_o, mem_resp_v_o
    );
endinterface

// File: rtl/bp_me_mem_serdes.sv
// Serializes full cce mem commands into header-qualified link beats and reassembles link beats into responses.
// Define BP_ME_MEM_SERDES_CRIT_FIRST_EN for critical-word-first beat ordering in both directions.
module bp_me_mem_serdes #(
    parameter int unsigned paddr_width_p     = 40,
    parameter int unsigned cce_block_width_p = 512,
    parameter int unsigned beat_width_p      = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_me_mem_serdes_if.slave     io
);
    localparam int unsigned beats_lp           = cce_block_width_p / beat_width_p;
    localparam int unsigned cnt_w_lp           = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int unsigned hdr_w_lp           = paddr_width_p + 7;
    localparam int unsigned msg_w_lp           = hdr_w_lp + cce_block_width_p;
    localparam int unsigned beat_bytes_log_lp  = $clog2(beat_width_p / 8);
    localparam logic [3:0]  e_cce_mem_uc_wr    = 4'd3;
    localparam logic [3:0]  e_cce_mem_wb       = 4'd5;

    typedef logic [beats_lp-1:0][beat_width_p-1:0] blk_t;

    // Index of the final beat: writes carry 2^size bytes, everything else a single empty beat.
    function automatic logic [cnt_w_lp-1:0] last_beat_idx(input logic [3:0] msg_type, input logic [2:0] size);
        int unsigned n;
        n = 32'd1;
        if ((msg_type == e_cce_mem_uc_wr || msg_type == e_cce_mem_wb) && (32'(size) > beat_bytes_log_lp))
            n = 32'd1 << (32'(size) - beat_bytes_log_lp);
        if (n > beats_lp)
            n = beats_lp;
        return cnt_w_lp'(n - 32'd1);
    endfunction

    typedef enum logic {e_cmd_ready, e_cmd_send} cmd_state_e;
    typedef enum logic {e_resp_fill, e_resp_out} resp_state_e;

    logic [hdr_w_lp-1:0] w_cmd_hdr;
    logic [3:0]          w_cmd_type;
    logic [2:0]          w_cmd_size;
    logic                w_cmd_wr;
    blk_t                w_cmd_blk;
    logic [cnt_w_lp-1:0] w_cmd_last_idx, w_cmd_off, w_cmd_nxt, w_cmd_idx;
    logic [cnt_w_lp-1:0] w_resp_off, w_resp_base, w_resp_slot;

    assign w_cmd_hdr      = io.mem_cmd_i[msg_w_lp-1 -: hdr_w_lp];
    assign w_cmd_type     = w_cmd_hdr[hdr_w_lp-1 -: 4];
    assign w_cmd_size     = w_cmd_hdr[paddr_width_p +: 3];
    assign w_cmd_wr       = (w_cmd_type == e_cce_mem_uc_wr) || (w_cmd_type == e_cce_mem_wb);
    assign w_cmd_blk      = w_cmd_wr ? blk_t'(io.mem_cmd_i[cce_block_width_p-1:0]) : '0;
    assign w_cmd_last_idx = last_beat_idx(w_cmd_type, w_cmd_size);

`ifdef BP_ME_MEM_SERDES_CRIT_FIRST_EN
    assign w_cmd_off  = w_cmd_hdr[beat_bytes_log_lp +: cnt_w_lp];
    assign w_resp_off = io.link_resp_header_i[beat_bytes_log_lp +: cnt_w_lp];
`else
    assign w_cmd_off  = '0;
    assign w_resp_off = '0;
`endif

    // ---------------- command serializer ----------------
    cmd_state_e              r_cmd_state;
    logic                    r_cmd_ready, r_cmd_v, r_cmd_last;
    logic [cnt_w_lp-1:0]     r_cmd_cnt, r_cmd_last_idx, r_cmd_off;
    blk_t                    r_cmd_data;
    logic [hdr_w_lp-1:0]     r_cmd_hdr;
    logic [beat_width_p-1:0] r_cmd_beat;

    assign w_cmd_nxt = r_cmd_cnt + cnt_w_lp'(1);
    assign w_cmd_idx = r_cmd_off + w_cmd_nxt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cmd_state    <= e_cmd_ready;
            r_cmd_ready    <= 1'b0;
            r_cmd_v        <= 1'b0;
            r_cmd_last     <= 1'b0;
            r_cmd_cnt      <= '0;
            r_cmd_last_idx <= '0;
            r_cmd_off      <= '0;
            r_cmd_data     <= '0;
            r_cmd_hdr      <= '0;
            r_cmd_beat     <= '0;
        end else begin
            case (r_cmd_state)
                e_cmd_ready: begin
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && io.mem_cmd_v_i) begin
                        r_cmd_state    <= e_cmd_send;
                        r_cmd_ready    <= 1'b0;
                        r_cmd_hdr      <= w_cmd_hdr;
                        r_cmd_data     <= w_cmd_blk;
                        r_cmd_off      <= w_cmd_off;
                        r_cmd_last_idx <= w_cmd_last_idx;
                        r_cmd_cnt      <= '0;
                        r_cmd_v        <= 1'b1;
                        r_cmd_beat     <= w_cmd_blk[w_cmd_off];
                        r_cmd_last     <= (w_cmd_last_idx == '0);
                    end
                end
                e_cmd_send: begin
                    if (io.link_cmd_yumi_i) begin
                        if (r_cmd_last) begin
                            r_cmd_state <= e_cmd_ready;
                            r_cmd_ready <= 1'b1;
                            r_cmd_v     <= 1'b0;
                            r_cmd_last  <= 1'b0;
                        end else begin
                            r_cmd_cnt  <= w_cmd_nxt;
                            r_cmd_beat <= r_cmd_data[w_cmd_idx];
                            r_cmd_last <= (w_cmd_nxt == r_cmd_last_idx);
                        end
                    end
                end
                default: r_cmd_state <= e_cmd_ready;
            endcase
        end
    end

    assign io.mem_cmd_ready_o   = r_cmd_ready;
    assign io.link_cmd_header_o = r_cmd_hdr;
    assign io.link_cmd_data_o   = r_cmd_beat;
    assign io.link_cmd_last_o   = r_cmd_last;
    assign io.link_cmd_v_o      = r_cmd_v;

    // ---------------- response assembler ----------------
    resp_state_e         r_resp_state;
    logic                r_resp_ready, r_resp_v;
    logic [cnt_w_lp-1:0] r_resp_cnt, r_resp_off;
    logic [hdr_w_lp-1:0] r_resp_hdr;
    blk_t                r_resp_data;

    // The first beat brings the header, so its offset is taken straight from the bus.
    assign w_resp_base = (r_resp_cnt == '0) ? w_resp_off : r_resp_off;
    assign w_resp_slot = w_resp_base + r_resp_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_resp_state <= e_resp_fill;
            r_resp_ready <= 1'b0;
            r_resp_v     <= 1'b0;
            r_resp_cnt   <= '0;
            r_resp_off   <= '0;
            r_resp_hdr   <= '0;
            r_resp_data  <= '0;
        end else begin
            case (r_resp_state)
                e_resp_fill: begin
                    r_resp_ready <= 1'b1;
                    if (r_resp_ready && io.link_resp_v_i) begin
                        if (r_resp_cnt == '0) begin
                            r_resp_hdr <= io.link_resp_header_i;
                            r_resp_off <= w_resp_off;
                        end
                        r_resp_data[w_resp_slot] <= io.link_resp_data_i;
                        if (io.link_resp_last_i) begin
                            r_resp_state <= e_resp_out;
                            r_resp_ready <= 1'b0;
                            r_resp_v     <= 1'b1;
                            r_resp_cnt   <= '0;
                        end else begin
                            r_resp_cnt <= r_resp_cnt + cnt_w_lp'(1);
                        end
                    end
                end
                e_resp_out: begin
                    if (io.mem_resp_yumi_i) begin
                        r_resp_state <= e_resp_fill;
                        r_resp_ready <= 1'b1;
                        r_resp_v     <= 1'b0;
                        r_resp_data  <= '0;
                    end
                end
                default: r_resp_state <= e_resp_fill;
            endcase
        end
    end

    assign io.link_resp_ready_o = r_resp_ready;
    assign io.mem_resp_o        = {r_resp_hdr, r_resp_data};
    assign io.mem_resp_v_o      = r_resp_v;

    // A full block of beats without last means the link lost framing; slot 0 is about to be overwritten.
    overrun_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(r_resp_state == e_resp_fill && r_resp_ready && io.link_resp_v_i && !io.link_resp_last_i
          && r_resp_cnt == cnt_w_lp'(beats_lp - 1)))
        else $error("bp_me_mem_serdes: response overrun, %0d beats without last", beats_lp);

endmodule
